// File: rtl/morse_timing_calibrator.sv
// Morse timing calibrator: measures live marks and publishes
// dit/dah/word/tolerance timing for the capture stage.
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif

module morse_timing_calibrator #(
  parameter int DEFAULT_DIT = 10,
  parameter int NUM_PULSES  = 4,
  parameter int MIN_PULSE   = 2,
  parameter int TIMEOUT     = 4000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    signal,
  input  logic                    start,
  output logic [`PULSE_CNT_W-1:0] dit_time,
  output logic [`PULSE_CNT_W-1:0] dah_time,
  output logic [`PULSE_CNT_W-1:0] word_time,
  output logic [`PULSE_CNT_W-1:0] tol_time,
  output logic                    busy,
  output logic                    cal_done,
  output logic                    cal_error
);

  localparam int W = `PULSE_CNT_W;
  localparam logic [W-1:0] DEF_W = W'(DEFAULT_DIT);
  localparam logic [W-1:0] MIN_W = W'(MIN_PULSE);
  localparam logic [W-1:0] TO_W  = W'(TIMEOUT);
  localparam logic [3:0]   NUM_W = 4'(NUM_PULSES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_CHECK,
    S_COMMIT,
    S_FAIL
  } state_e;

  function automatic logic [W-1:0] mul_sat(
    input logic [W-1:0] d,
    input logic [2:0]   k
  );
    logic [W+2:0] p;
    p = {3'b000, d} * {{W{1'b0}}, k};
    mul_sat = (|p[W+2:W]) ? '1 : p[W-1:0];
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] dit_q, dit_d;
  logic [W-1:0] dah_q, dah_d;
  logic [W-1:0] word_q, word_d;
  logic [W-1:0] tol_q, tol_d;
  logic [W-1:0] mark_q, mark_d;
  logic [W-1:0] low_q, low_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;
  logic [3:0]   n_q, n_d;
  logic         prev_q, prev_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  always_comb begin
    state_d = state_q;
    dit_d   = dit_q;
    dah_d   = dah_q;
    word_d  = word_q;
    tol_d   = tol_q;
    mark_d  = mark_q;
    low_d   = low_q;
    min_d   = min_q;
    max_d   = max_q;
    n_d     = n_q;
    prev_d  = prev_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (ce) prev_d = signal;
    unique case (state_q)
      S_IDLE: begin
        // busy_q lingers one clk after a pulse so a coincident start is dropped
        if (start && !busy_q) begin
          state_d = S_ARM;
          mark_d  = '0;
          low_d   = '0;
          min_d   = '1;
          max_d   = '0;
          n_d     = '0;
        end
      end
      S_ARM: begin
        if (ce && !signal) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (ce) begin
          if (signal) begin
            if (mark_q != '1) mark_d = mark_q + 1'b1;
            low_d = '0;
          end else begin
            low_d = low_q + 1'b1;
            if (prev_q) begin
              if (mark_q >= MIN_W) begin
                if (mark_q < min_q) min_d = mark_q;
                if (mark_q > max_q) max_d = mark_q;
                n_d = n_q + 1'b1;
              end
              mark_d = '0;
            end
          end
          if (n_d == NUM_W) state_d = S_CHECK;
          else if (low_d == TO_W || mark_d == TO_W) state_d = S_FAIL;
        end
      end
      S_CHECK: begin
        state_d = ({1'b0, max_q} >= {min_q, 1'b0}) ? S_COMMIT : S_FAIL;
      end
      S_COMMIT: begin
        dit_d   = min_q;
        dah_d   = mul_sat(min_q, 3'd3);
        word_d  = mul_sat(min_q, 3'd7);
        tol_d   = min_q >> 1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || (state_q == S_COMMIT) ||
             (state_q == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dit_q   <= DEF_W;
      dah_q   <= mul_sat(DEF_W, 3'd3);
      word_q  <= mul_sat(DEF_W, 3'd7);
      tol_q   <= DEF_W >> 1;
      mark_q  <= '0;
      low_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      n_q     <= '0;
      prev_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dit_q   <= dit_d;
      dah_q   <= dah_d;
      word_q  <= word_d;
      tol_q   <= tol_d;
      mark_q  <= mark_d;
      low_q   <= low_d;
      min_q   <= min_d;
      max_q   <= max_d;
      n_q     <= n_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dit_time  = dit_q;
  assign dah_time  = dah_q;
  assign word_time = word_q;
  assign tol_time  = tol_q;
  assign busy      = busy_q;
  assign cal_done  = done_q;
  assign cal_error = err_q;

endmodule

// File: tb/tb_morse_timing_calibrator.sv
// Directed bench for morse_timing_calibrator.
// Expected timing sets and latencies are hand-computed.
`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif

module tb_morse_timing_calibrator;

  localparam int W = `PULSE_CNT_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         signal;
  logic         start;
  logic [W-1:0] dit_time;
  logic [W-1:0] dah_time;
  logic [W-1:0] word_time;
  logic [W-1:0] tol_time;
  logic         busy;
  logic         cal_done;
  logic         cal_error;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int lat;
  int snap_d;
  int snap_e;

  morse_timing_calibrator dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .signal    (signal),
    .start     (start),
    .dit_time  (dit_time),
    .dah_time  (dah_time),
    .word_time (word_time),
    .tol_time  (tol_time),
    .busy      (busy),
    .cal_done  (cal_done),
    .cal_error (cal_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cal_done) done_cnt++;
    if (cal_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic mark(input int len, input int gap);
    signal = 1'b1;
    ticks(len);
    signal = 1'b0;
    ticks(gap);
  endtask

  task automatic wait_pulse(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cal_done || cal_error) && n < bound);
  endtask

  task automatic chk_set(input string tag, input int d, input int a,
                         input int w, input int t);
    chk({tag, "_dit"}, 32'(dit_time), 32'(d));
    chk({tag, "_dah"}, 32'(dah_time), 32'(a));
    chk({tag, "_word"}, 32'(word_time), 32'(w));
    chk({tag, "_tol"}, 32'(tol_time), 32'(t));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    ce     = 1'b1;
    signal = 1'b0;
    start  = 1'b0;
    ticks(3);
    rst = 1'b0;
    ticks(3);

    // 1: reset defaults
    chk_set("rst", 10, 30, 70, 5);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);

    // 4: all marks equal -> ambiguous -> error
    pulse_start();
    chk("t4_busy", 32'(busy), 32'd1);
    tick();
    mark(30, 20);
    mark(30, 20);
    mark(30, 20);
    mark(30, 0);
    wait_pulse(10, lat);
    chk("t4_lat", 32'(lat), 32'd3);
    chk("t4_err", 32'(cal_error), 32'd1);
    chk("t4_done", 32'(cal_done), 32'd0);
    chk_set("t4", 10, 30, 70, 5);
    ticks(3);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_ecnt", 32'(err_cnt), 32'd1);

    // 2: 20,60,20,20 -> dit 20; start coincident with done dropped
    pulse_start();
    tick();
    mark(20, 20);
    mark(60, 20);
    mark(20, 20);
    mark(20, 0);
    wait_pulse(10, lat);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_done", 32'(cal_done), 32'd1);
    chk("t2_bsy", 32'(busy), 32'd1);
    chk_set("t2", 20, 60, 140, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_coinc", 32'(busy), 32'd0);
    ticks(3);
    chk("t2_coinc2", 32'(busy), 32'd0);
    chk("t2_dcnt", 32'(done_cnt), 32'd1);

    // 3: 1-tick glitch ignored
    do_reset();
    chk_set("t3r", 10, 30, 70, 5);
    pulse_start();
    tick();
    mark(20, 20);
    mark(1, 20);
    mark(60, 20);
    mark(20, 20);
    mark(20, 0);
    wait_pulse(10, lat);
    chk("t3_lat", 32'(lat), 32'd3);
    chk("t3_done", 32'(cal_done), 32'd1);
    chk_set("t3", 20, 60, 140, 10);
    ticks(2);
    chk("t3_dcnt", 32'(done_cnt), 32'd2);

    // 5: low timeout after one mark
    pulse_start();
    tick();
    mark(20, 0);
    wait_pulse(5000, lat);
    chk("t5_lat", 32'(lat), 32'd4001);
    chk("t5_err", 32'(cal_error), 32'd1);
    chk_set("t5", 20, 60, 140, 10);
    ticks(3);
    chk("t5_busy", 32'(busy), 32'd0);

    // 6a: mark in progress at start is skipped
    do_reset();
    signal = 1'b1;
    pulse_start();
    ticks(59);
    signal = 1'b0;
    ticks(20);
    mark(20, 20);
    mark(20, 20);
    mark(20, 20);
    mark(20, 0);
    wait_pulse(10, lat);
    chk("t6a_err", 32'(cal_error), 32'd1);
    chk("t6a_done", 32'(cal_done), 32'd0);
    ticks(3);

    // 6b: reset mid-measure
    snap_d = done_cnt;
    snap_e = err_cnt;
    pulse_start();
    tick();
    mark(20, 20);
    signal = 1'b1;
    ticks(5);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    signal = 1'b0;
    chk("t6b_busy", 32'(busy), 32'd0);
    chk_set("t6b", 10, 30, 70, 5);
    ticks(10);
    chk("t6b_dcnt", 32'(done_cnt), 32'(snap_d));
    chk("t6b_ecnt", 32'(err_cnt), 32'(snap_e));

    // 6c: start while busy ignored
    pulse_start();
    tick();
    mark(20, 20);
    mark(60, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(9);
    mark(20, 20);
    mark(20, 0);
    wait_pulse(10, lat);
    chk("t6c_lat", 32'(lat), 32'd3);
    chk("t6c_done", 32'(cal_done), 32'd1);
    ticks(50);
    chk("t6c_dcnt", 32'(done_cnt), 32'(snap_d + 1));
    chk("t6c_busy", 32'(busy), 32'd0);
    chk_set("t6c", 20, 60, 140, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
